// File: rtl/xbar_wrr_arbiter_pkg.sv
// Shared types and width helper for the stream crossbar arbiter slice.
package xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xbar_wrr_arbiter_if.sv
// Request/grant bundle between one crossbar output port and its arbiter.
interface xbar_wrr_arbiter_if
    import xbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 2,
    parameter int T_ID___WIDTH = clog2_min1(S_DATA_COUNT),
    parameter int WEIGHT_WIDTH = 4
);
    logic [S_DATA_COUNT-1:0]              req_i;
    logic [S_DATA_COUNT-1:0]              last_i;
    logic                                 beat_i;
    logic [S_DATA_COUNT*WEIGHT_WIDTH-1:0] weight_i;
    logic                                 grant_valid_o;
    logic [T_ID___WIDTH-1:0]              grant_id_o;
    logic [S_DATA_COUNT-1:0]              grant_oh_o;

    modport master (
        output req_i, last_i, beat_i, weight_i,
        input  grant_valid_o, grant_id_o, grant_oh_o
    );

    modport slave (
        input  req_i, last_i, beat_i, weight_i,
        output grant_valid_o, grant_id_o, grant_oh_o
    );
endinterface

// File: rtl/xbar_wrr_arbiter_picker.sv
// Round-robin search: first set request at or after ptr_i, wrapping to 0.
module rr_priority_picker
    import xbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 2,
    parameter int T_ID___WIDTH = clog2_min1(S_DATA_COUNT)
) (
    input  logic [S_DATA_COUNT-1:0] req_i,
    input  logic [T_ID___WIDTH-1:0] ptr_i,
    output logic                    found_o,
    output logic [T_ID___WIDTH-1:0] winner_o
);
    localparam int IW = T_ID___WIDTH + 1;
    localparam int DW = 1 << IW;

    logic [DW-1:0] req_dbl;
    logic [IW-1:0] idx;

    // Scanning from the farthest offset down lets the nearest request win.
    always_comb begin
        req_dbl  = DW'({req_i, req_i});
        found_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int i = S_DATA_COUNT - 1; i >= 0; i--) begin
            idx = IW'(ptr_i) + IW'(i);
            if (req_dbl[idx]) begin
                found_o  = 1'b1;
                winner_o = (idx >= IW'(S_DATA_COUNT)) ? T_ID___WIDTH'(idx - IW'(S_DATA_COUNT))
                                                      : T_ID___WIDTH'(idx);
            end
        end
    end
endmodule

// File: rtl/xbar_wrr_arbiter.sv
// Weighted round-robin packet arbiter for one crossbar output port.
//   state | meaning
//   IDLE  | no grant; next requester picked from ptr_q onward
//   BUSY  | packet in flight for grant_id_q
//   HOLD  | packet done, grant kept while credit remains
module xbar_wrr_arbiter
    import xbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 2,
    parameter int T_ID___WIDTH = clog2_min1(S_DATA_COUNT),
    parameter int WEIGHT_WIDTH = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    xbar_wrr_arbiter_if.slave arb_if
);
    arb_state_t              state_q;
    logic [T_ID___WIDTH-1:0] ptr_q;
    logic [WEIGHT_WIDTH-1:0] credit_q;
    logic                    grant_valid_q;
    logic [T_ID___WIDTH-1:0] grant_id_q;
    logic [S_DATA_COUNT-1:0] grant_oh_q;

    logic                    found;
    logic [T_ID___WIDTH-1:0] winner;
    logic [WEIGHT_WIDTH-1:0] weight_arr [S_DATA_COUNT];
    logic [WEIGHT_WIDTH-1:0] credit_start_d;
    logic [WEIGHT_WIDTH-1:0] credit_dec_d;
    logic [T_ID___WIDTH-1:0] ptr_d;
    logic                    eop_d;

    rr_priority_picker #(
        .S_DATA_COUNT (S_DATA_COUNT),
        .T_ID___WIDTH (T_ID___WIDTH)
    ) u_picker (
        .req_i    (arb_if.req_i),
        .ptr_i    (ptr_q),
        .found_o  (found),
        .winner_o (winner)
    );

    always_comb begin
        for (int k = 0; k < S_DATA_COUNT; k++) begin
            weight_arr[k] = arb_if.weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
        // A zero weight would otherwise underflow the credit on the first EOP.
        credit_start_d = (weight_arr[winner] == '0) ? WEIGHT_WIDTH'(1) : weight_arr[winner];
        credit_dec_d   = credit_q - WEIGHT_WIDTH'(1);
        ptr_d          = (grant_id_q == T_ID___WIDTH'(S_DATA_COUNT - 1)) ? '0
                                                                         : grant_id_q + T_ID___WIDTH'(1);
        eop_d          = arb_if.beat_i && arb_if.last_i[grant_id_q];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            credit_q      <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            grant_oh_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q       <= BUSY;
                        grant_valid_q <= 1'b1;
                        grant_id_q    <= winner;
                        grant_oh_q    <= S_DATA_COUNT'(1) << winner;
                        credit_q      <= credit_start_d;
                    end
                end
                BUSY: begin
                    if (eop_d) begin
                        credit_q <= credit_dec_d;
                        if (credit_dec_d == '0) begin
                            state_q       <= IDLE;
                            ptr_q         <= ptr_d;
                            grant_valid_q <= 1'b0;
                            grant_oh_q    <= '0;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (arb_if.req_i[grant_id_q]) begin
                        state_q <= BUSY;
                    end else begin
                        state_q       <= IDLE;
                        ptr_q         <= ptr_d;
                        credit_q      <= '0;
                        grant_valid_q <= 1'b0;
                        grant_oh_q    <= '0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    grant_valid_q <= 1'b0;
                    grant_oh_q    <= '0;
                end
            endcase
        end
    end

    assign arb_if.grant_valid_o = grant_valid_q;
    assign arb_if.grant_id_o    = grant_id_q;
    assign arb_if.grant_oh_o    = grant_oh_q;
endmodule

// File: tb/tb_xbar_wrr_arbiter.sv
// Directed vector bench for the two-requester weighted round-robin arbiter.
module tb_xbar_wrr_arbiter;
    import xbar_pkg::*;

    localparam int N = 2;
    localparam int T = 1;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    xbar_wrr_arbiter_if #(.S_DATA_COUNT(N), .T_ID___WIDTH(T), .WEIGHT_WIDTH(W)) arb_if ();

    xbar_wrr_arbiter #(.S_DATA_COUNT(N), .T_ID___WIDTH(T), .WEIGHT_WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .arb_if (arb_if)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] req;
        logic [1:0] last;
        logic       beat;
        logic [3:0] w0;
        logic [3:0] w1;
        logic       exp_v;
        logic       exp_id;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(string name, logic r, logic [1:0] req, logic [1:0] last, logic beat,
                                logic [3:0] w0, logic [3:0] w1, logic ev, logic eid);
        vec_t v;
        v.name = name; v.rst = r; v.req = req; v.last = last; v.beat = beat;
        v.w0 = w0; v.w1 = w1; v.exp_v = ev; v.exp_id = eid;
        vecs.push_back(v);
    endfunction

    task automatic drive(logic r, logic [1:0] req, logic [1:0] last, logic beat,
                         logic [3:0] w0, logic [3:0] w1);
        rst             = r;
        arb_if.req_i    = req;
        arb_if.last_i   = last;
        arb_if.beat_i   = beat;
        arb_if.weight_i = {w1, w0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(string name, logic ev, logic eid);
        logic [1:0] exp_oh;
        exp_oh = ev ? (2'b01 << eid) : 2'b00;
        n_tests++;
        if (arb_if.grant_valid_o !== ev || (ev && arb_if.grant_id_o !== eid) ||
            arb_if.grant_oh_o !== exp_oh) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b id=%0d oh=%b, expected valid=%0b id=%0d oh=%b",
                     name, arb_if.grant_valid_o, arb_if.grant_id_o, arb_if.grant_oh_o,
                     ev, eid, exp_oh);
        end
    endtask

    initial begin
        drive(1'b1, 2'b00, 2'b00, 1'b0, 4'd1, 4'd1);

        // 1: weights 1/1, single-beat packets alternate with one idle cycle
        add("t1_reset", 1, 2'b11, 2'b11, 1, 1, 1, 0, 0);
        add("t1_g0a",   0, 2'b11, 2'b11, 1, 1, 1, 1, 0);
        add("t1_idle1", 0, 2'b11, 2'b11, 1, 1, 1, 0, 0);
        add("t1_g1a",   0, 2'b11, 2'b11, 1, 1, 1, 1, 1);
        add("t1_idle2", 0, 2'b11, 2'b11, 1, 1, 1, 0, 0);
        add("t1_g0b",   0, 2'b11, 2'b11, 1, 1, 1, 1, 0);
        add("t1_idle3", 0, 2'b11, 2'b11, 1, 1, 1, 0, 0);
        add("t1_g1b",   0, 2'b11, 2'b11, 1, 1, 1, 1, 1);
        add("t1_idle4", 0, 2'b11, 2'b11, 1, 1, 1, 0, 0);
        // 2: weight 3/1, 2-beat packets; w0 changed mid-grant must not matter
        add("t2_g0",     0, 2'b11, 2'b00, 0, 3, 1, 1, 0);
        add("t2_p1b1",   0, 2'b11, 2'b00, 1, 1, 1, 1, 0);
        add("t2_p1eop",  0, 2'b11, 2'b01, 1, 1, 1, 1, 0);
        add("t2_hold1",  0, 2'b11, 2'b00, 0, 1, 1, 1, 0);
        add("t2_p2b1",   0, 2'b11, 2'b00, 1, 1, 1, 1, 0);
        add("t2_p2eop",  0, 2'b11, 2'b01, 1, 1, 1, 1, 0);
        add("t2_hold2",  0, 2'b11, 2'b00, 0, 1, 1, 1, 0);
        add("t2_p3b1",   0, 2'b11, 2'b00, 1, 1, 1, 1, 0);
        add("t2_p3eop",  0, 2'b11, 2'b01, 1, 1, 1, 0, 0);
        add("t2_g1",     0, 2'b11, 2'b00, 0, 1, 1, 1, 1);
        add("t2_g1b1",   0, 2'b11, 2'b00, 1, 1, 1, 1, 1);
        add("t2_g1eop",  0, 2'b11, 2'b10, 1, 1, 1, 0, 0);
        add("t2_g0again",0, 2'b11, 2'b00, 0, 1, 1, 1, 0);
        // 3: 4-beat packet with requester drop and stalls; other last ignored
        add("t3_reset",  1, 2'b11, 2'b00, 0, 1, 1, 0, 0);
        add("t3_g0",     0, 2'b11, 2'b00, 0, 1, 1, 1, 0);
        add("t3_beat1",  0, 2'b11, 2'b00, 1, 1, 1, 1, 0);
        add("t3_drop_a", 0, 2'b10, 2'b01, 0, 1, 1, 1, 0);
        add("t3_drop_b", 0, 2'b10, 2'b01, 0, 1, 1, 1, 0);
        add("t3_oth_lst",0, 2'b11, 2'b10, 1, 1, 1, 1, 0);
        add("t3_beat3",  0, 2'b11, 2'b00, 1, 1, 1, 1, 0);
        add("t3_eop",    0, 2'b11, 2'b01, 1, 1, 1, 0, 0);
        add("t3_g1",     0, 2'b11, 2'b00, 0, 1, 1, 1, 1);
        // 4: requester leaves during HOLD -> release, pointer moves to 1
        add("t4_reset",  1, 2'b11, 2'b00, 0, 2, 1, 0, 0);
        add("t4_g0",     0, 2'b11, 2'b00, 0, 2, 1, 1, 0);
        add("t4_eop",    0, 2'b11, 2'b01, 1, 2, 1, 1, 0);
        add("t4_hold_rl",0, 2'b10, 2'b00, 0, 2, 1, 0, 0);
        add("t4_g1",     0, 2'b11, 2'b00, 0, 2, 1, 1, 1);
        add("t4_g1eop",  0, 2'b11, 2'b10, 1, 2, 1, 0, 0);
        // 5: weight 0 behaves as weight 1
        add("t5_g0",     0, 2'b11, 2'b00, 0, 1, 0, 1, 0);
        add("t5_g0eop",  0, 2'b11, 2'b01, 1, 1, 0, 0, 0);
        add("t5_g1",     0, 2'b11, 2'b00, 0, 1, 0, 1, 1);
        add("t5_g1eop",  0, 2'b11, 2'b10, 1, 1, 0, 0, 0);
        // 6: reset mid-packet while ptr=1 restores ptr=0
        add("t6_g0",     0, 2'b11, 2'b00, 0, 1, 0, 1, 0);
        add("t6_g0eop",  0, 2'b11, 2'b01, 1, 1, 0, 0, 0);
        add("t6_g1",     0, 2'b11, 2'b00, 0, 1, 0, 1, 1);
        add("t6_g1b1",   0, 2'b11, 2'b00, 1, 1, 0, 1, 1);
        add("t6_rst",    1, 2'b11, 2'b00, 1, 1, 0, 0, 0);
        add("t6_post",   0, 2'b11, 2'b00, 0, 1, 0, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].last, vecs[i].beat, vecs[i].w0, vecs[i].w1);
            tick();
            check_grant(vecs[i].name, vecs[i].exp_v, vecs[i].exp_id);
        end

        // 7: full 4-bit weight, 15 single-beat packets back-to-back, then switch
        drive(1'b1, 2'b11, 2'b00, 1'b0, 4'd15, 4'd1);
        tick();
        check_grant("t7_reset", 1'b0, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 1'b0, 4'd15, 4'd1);
        tick();
        check_grant("t7_g0", 1'b1, 1'b0);
        for (int p = 1; p <= 15; p++) begin
            drive(1'b0, 2'b11, 2'b01, 1'b1, 4'd15, 4'd1);
            tick();
            check_grant($sformatf("t7_eop%0d", p), (p < 15), 1'b0);
            if (p < 15) begin
                drive(1'b0, 2'b11, 2'b00, 1'b0, 4'd15, 4'd1);
                tick();
                check_grant($sformatf("t7_hold%0d", p), 1'b1, 1'b0);
            end
        end
        drive(1'b0, 2'b11, 2'b00, 1'b0, 4'd15, 4'd1);
        begin
            int waited;
            waited = 0;
            while (arb_if.grant_valid_o !== 1'b1 && waited < 4) begin
                tick();
                waited++;
            end
            if (arb_if.grant_valid_o !== 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL t7_wait_g1: grant_valid still %0b after %0d cycles, required 1",
                         arb_if.grant_valid_o, waited);
            end else begin
                check_grant("t7_g1", 1'b1, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
